// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver state encoding and the
// bit-period mid-point helper used by the receiver and, later, the transmitter.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  // Sample point inside a bit period, counted from the period's first cycle.
  function automatic int unsigned mid_point(input int unsigned cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/uartrx_param_if.sv
// Word-side port of the UART receiver.
// Handshake: the receiver raises out__valid with out__data and the error
// flags stable; the word transfers on any clock edge where out__valid and
// in__ready are both high; out__valid never drops without a transfer, and
// in__ready may be driven independently of out__valid.
interface uartrx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] out__data;
  logic                 out__valid;
  logic                 in__ready;
  logic                 out__parity_err;
  logic                 out__frame_err;
  logic                 out__overrun;

  modport master (
    output out__data, out__valid, out__parity_err, out__frame_err, out__overrun,
    input  in__ready
  );

  modport slave (
    input  out__data, out__valid, out__parity_err, out__frame_err, out__overrun,
    output in__ready
  );
endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous, idle-high serial input.
// Resets to 1 so the line reads as idle straight out of reset.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the raw input through STAGES flops.
  always_ff @(posedge clk) begin
    if (rst) sr <= '1;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/uartrx_param.sv
// Parametrised UART receiver: synchronised input, false-start rejection,
// optional parity, 1 or 2 stop bits, break handling, and a one-word holding
// register with sticky overrun towards a valid/ready consumer.
module uartrx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 37,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in__rx,
  uartrx_param_if.master  rx_if,
  output rx_state_t       dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CTR_MID   = CW'(mid_point(CLKS_PER_BIT));
  localparam logic [CW-1:0] CTR_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_DLAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_SLAST = IW'(STOP_BITS - 1);
  localparam logic          ODD_MODE  = (PARITY == PAR_ODD);
  localparam logic          HAS_PAR   = (PARITY != PAR_NONE);

  logic                 s_rx;
  rx_state_t            state, state_n;
  logic [CW-1:0]        ctr, ctr_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 par, par_n;
  logic                 perr, perr_n;
  logic                 ferr, ferr_n;
  logic                 done;
  logic                 mid, last;

  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, ovr_q;
  logic                 hs;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in__rx),
    .q   (s_rx)
  );

  assign mid  = (ctr == CTR_MID);
  assign last = (ctr == CTR_LAST);
  assign hs   = valid_q & rx_if.in__ready;

  // Frame state machine: next state plus bit counter, shift register and flags.
  always_comb begin
    state_n = state;
    ctr_n   = last ? '0 : ctr + 1'b1;
    idx_n   = idx;
    sh_n    = sh;
    par_n   = par;
    perr_n  = perr;
    ferr_n  = ferr;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        ctr_n = '0;
        if (!s_rx) begin
          state_n = ST_START;
          ctr_n   = CW'(1);
          par_n   = 1'b0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      ST_START: begin
        if (mid && s_rx) begin
          state_n = ST_IDLE;
        end else if (last) begin
          state_n = ST_DATA;
          idx_n   = '0;
        end
      end
      ST_DATA: begin
        if (mid) begin
          sh_n  = {s_rx, sh[DATA_BITS-1:1]};
          par_n = par ^ s_rx;
        end
        if (last) begin
          if (idx == IDX_DLAST) begin
            idx_n   = '0;
            state_n = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (mid)  perr_n  = ((s_rx ^ par) != ODD_MODE);
        if (last) state_n = ST_STOP;
      end
      ST_STOP: begin
        if (mid) begin
          ferr_n = ferr | ~s_rx;
          // Finish at the last stop bit's mid-point so an immediately
          // following start edge is not missed.
          if (idx == IDX_SLAST) begin
            done    = 1'b1;
            state_n = ferr_n ? ST_BREAK : ST_IDLE;
          end
        end else if (last) begin
          idx_n = idx + 1'b1;
        end
      end
      ST_BREAK: begin
        if (s_rx) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ctr   <= '0;
      idx   <= '0;
      sh    <= '0;
      par   <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      state <= state_n;
      ctr   <= ctr_n;
      idx   <= idx_n;
      sh    <= sh_n;
      par   <= par_n;
      perr  <= perr_n;
      ferr  <= ferr_n;
    end
  end

  // Holding register: load on completion if empty or draining this cycle,
  // otherwise drop the new frame and flag overrun (a drop beats the clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (done) begin
        if (!valid_q || hs) begin
          data_q  <= sh;
          perr_q  <= perr;
          ferr_q  <= ferr_n;
          valid_q <= 1'b1;
        end
      end else if (hs) begin
        valid_q <= 1'b0;
      end
      if (done && valid_q && !hs) ovr_q <= 1'b1;
      else if (hs)                ovr_q <= 1'b0;
    end
  end

  assign rx_if.out__data       = data_q;
  assign rx_if.out__valid      = valid_q;
  assign rx_if.out__parity_err = perr_q;
  assign rx_if.out__frame_err  = ferr_q;
  assign rx_if.out__overrun    = ovr_q;
  assign dbg_state             = state;

endmodule

// File: doc/uartrx_param.md
Name: uartrx_param

Overview:
- Parametrised successor to the fixed 8N1 UART receiver.
- Runtime-invariant generics: bit period, data width, parity mode and stop-bit count.
- Adds an input synchroniser, false-start rejection, parity/framing error flags, break handling and overrun detection.
- Sits between the pad-side serial line and a valid/ready byte consumer (e.g. rx FIFO or command decoder).

Parameters:
CLKS_PER_BIT, 37, clock cycles per serial bit (>=4)
DATA_BITS, 8, payload bits per frame (5..9)
PARITY, 0, 0 none, 1 even, 2 odd
STOP_BITS, 1, stop bits checked (1 or 2)
SYNC_STAGES, 2, synchroniser flops on in__rx (>=2)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
in__rx  input  1  asynchronous serial line, idle high
in__ready  input  1  consumer accepts word when high with out__valid
out__data  output  DATA_BITS  received word, LSB first on line
out__valid  output  1  word held valid until accepted
out__parity_err  output  1  parity mismatch for held word; 0 when PARITY=0
out__frame_err  output  1  any checked stop bit sampled low for held word
out__overrun  output  1  sticky: a frame was dropped while holding a word

Behaviour:
- Reset:
  - synchroniser flops <= 1
  - state <= IDLE
  - out__valid, out__overrun, out__parity_err, out__frame_err <= 0
  - out__data <= 0
  - A reset mid-frame discards the frame with no output.
- Synchroniser: s_rx = in__rx delayed SYNC_STAGES cycles. All logic below uses s_rx only.
- Bit timing:
  - MID = CLKS_PER_BIT/2 (floor).
  - T0 = first cycle in IDLE with s_rx==0.
  - Bit k (k=0 is start) is sampled at cycle T0 + k*CLKS_PER_BIT + MID.
  - Counter width is clog2(CLKS_PER_BIT). It wraps to 0 after CLKS_PER_BIT-1.
- States:
  - IDLE: s_rx==0 -> START, ctr=1.
  - START: at MID, s_rx==1 -> IDLE (false start, no output); else continue. At period end -> DATA, bit index=0.
  - DATA: at MID, shift s_rx into shift register LSB-first and fold it into the running parity. After DATA_BITS samples -> PARITY if PARITY!=0, else STOP.
  - PARITY: at MID, perr = (sample ^ data parity) != (PARITY==2). Then -> STOP.
  - STOP:
    - Sample at MID of each stop bit; ferr |= ~sample.
    - At the MID of the last stop bit the frame completes.
    - On completion: ferr==0 -> IDLE; ferr==1 -> BREAK.
    - Do not wait for the period end, so a back-to-back start edge is caught.
  - BREAK: stay until s_rx==1, then -> IDLE. No new start is detected while the line is held low.
- Frame completion (cycle C; outputs update at C+1):
  - holding empty (out__valid=0), or handshake in C (out__valid & in__ready) -> load data/perr/ferr, out__valid=1
  - holding full and no handshake in C -> drop frame, keep old word, out__overrun=1
- Handshake:
  - out__valid & in__ready in a cycle with no completion -> out__valid=0 next cycle.
  - out__data and the error flags are undefined (held) while out__valid=0.
  - out__overrun clears on the cycle after any handshake, unless a drop occurs in that same cycle (the drop wins).
- Latency: out__valid rises at T0 + (1+DATA_BITS+(PARITY!=0)+STOP_BITS-1)*CLKS_PER_BIT + MID + 1.
- DATA_BITS=9 with PARITY!=0 is legal.
- All arithmetic is unsigned. The counter and bit index are sized to their maxima, with no overflow.

Decomposition:
- Shared package uart_pkg holds:
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD
  - state encoding IDLE/START/DATA/PARITY/STOP/BREAK
  - helper function mid_point(CLKS_PER_BIT)
- One natural sub-module: uart_sync, the SYNC_STAGES-deep reset-to-1 synchroniser, reused later by the transmitter's CTS input.

Test Plan:
- 8N1, CPB=37, in__ready=1; send 0xA5 with rx falling at t -> out__data=0xA5, out__valid high exactly at t+2+352 for one cycle, perr=ferr=0.
- PARITY=1 (even); send 0x07 with parity bit 1 -> perr=0. Repeat with parity bit 0 -> out__parity_err=1, data 0x07 still delivered.
- 8N1, in__ready=0; send 0x11 then 0x22 back-to-back -> out__data stays 0x11, out__overrun=1 after the second frame. Raise in__ready -> out__valid drops next cycle and overrun clears.
- Glitch: rx low for 10 cycles (<MID) -> no output; state back in IDLE; a following frame 0x3C is received correctly.
- Break: rx low for 20 bit periods -> one word 0x00 with out__frame_err=1, then nothing until rx high. The next frame 0x5A is received cleanly.
- Assert rst for 1 cycle mid-way through data bit 4 -> all outputs 0 next cycle, no word emitted. The next full frame 0xC3 is received correctly.
